// File: rtl/clock_pkg.sv
// rtl/clock_pkg.sv - shared clock/alarm types, BCD limits and BCD increment helper
package clock_pkg;

  typedef enum logic [2:0] {
    ST_OFF,
    ST_ARMED,
    ST_EDIT_HH,
    ST_EDIT_MM,
    ST_RINGING,
    ST_SNOOZE
  } alm_state_e;

  localparam logic [7:0] BCD_HH_MAX = 8'h23;
  localparam logic [7:0] BCD_MM_MAX = 8'h59;

  // Values at or above max wrap to zero, so a corrupted field recovers to a legal BCD value.
  function automatic logic [7:0] bcd_inc_wrap(input logic [7:0] v, input logic [7:0] max);
    logic [7:0] r;
    if (v >= max)
      r = 8'h00;
    else if (v[3:0] >= 4'd9)
      r = {v[7:4] + 4'd1, 4'd0};
    else
      r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

endpackage

// File: rtl/alarm_tone_gen.sv
// rtl/alarm_tone_gen.sv - 50% square-wave buzzer carrier, divider held cleared while en=0
module alarm_tone_gen #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int TONE_HZ  = 2000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tone
);

  localparam int HALF = CLK_FREQ / (2 * TONE_HZ);
  localparam int CW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      cnt  <= '0;
      tone <= 1'b0;
    end else if (cnt == HALF_LAST) begin
      cnt  <= '0;
      tone <= ~tone;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/alarm_controller.sv
// rtl/alarm_controller.sv - HH:MM alarm with edit, arm, ring and auto-silence
// Optional snooze state enabled by defining ALARM_SNOOZE_EN.
module alarm_controller
  import clock_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int TONE_HZ    = 2000,
  parameter int RING_SECS  = 60,
  parameter int SNOOZE_MIN = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clk_1hz_tick,
  input  logic [7:0] cur_hh,
  input  logic [7:0] cur_mm,
  input  logic [7:0] cur_ss,
  input  logic       set_en,
  input  logic       alm_set_p,
  input  logic       alm_sel_p,
  input  logic       alm_inc_p,
  input  logic       alm_on_p,
  input  logic       stop_p,
  output logic [7:0] alm_hh,
  output logic [7:0] alm_mm,
  output logic       alm_edit,
  output logic       alm_blink_sel,
  output logic       armed,
  output logic       ringing,
  output logic       snoozing,
  output logic       buzzer
);

  localparam int RW = $clog2(RING_SECS + 1);
  localparam logic [RW-1:0] RING_END = RW'(RING_SECS);

  alm_state_e    state, nxt_state;
  logic [7:0]    nxt_hh, nxt_mm;
  logic          saved_armed, nxt_saved;
  logic [RW-1:0] ring_cnt, nxt_ring;
  logic          match, match_q, tone;

`ifdef ALARM_SNOOZE_EN
  localparam int SW = $clog2(SNOOZE_MIN * 60 + 1);
  localparam logic [SW-1:0] SNZ_END = SW'(SNOOZE_MIN * 60);
  logic [SW-1:0] snz_cnt, nxt_snz;
`endif

  assign match = (cur_hh == alm_hh) && (cur_mm == alm_mm) && (cur_ss == 8'h00);

  always_comb begin
    nxt_state = state;
    nxt_hh    = alm_hh;
    nxt_mm    = alm_mm;
    nxt_saved = saved_armed;
    nxt_ring  = ring_cnt;
`ifdef ALARM_SNOOZE_EN
    nxt_snz   = snz_cnt;
`endif
    case (state)
      ST_OFF, ST_ARMED: begin
        if (alm_set_p) begin
          nxt_state = ST_EDIT_HH;
          nxt_saved = (state == ST_ARMED);
        end else if (alm_on_p) begin
          nxt_state = (state == ST_OFF) ? ST_ARMED : ST_OFF;
        end else if (state == ST_ARMED && match && !match_q && !set_en) begin
          nxt_state = ST_RINGING;
          nxt_ring  = '0;
        end
      end
      ST_EDIT_HH, ST_EDIT_MM: begin
        if (alm_set_p)
          nxt_state = saved_armed ? ST_ARMED : ST_OFF;
        else if (alm_sel_p)
          nxt_state = (state == ST_EDIT_HH) ? ST_EDIT_MM : ST_EDIT_HH;
        else if (alm_inc_p && state == ST_EDIT_HH)
          nxt_hh = bcd_inc_wrap(alm_hh, BCD_HH_MAX);
        else if (alm_inc_p)
          nxt_mm = bcd_inc_wrap(alm_mm, BCD_MM_MAX);
      end
      ST_RINGING: begin
        if (alm_on_p) begin
          nxt_state = ST_OFF;
          nxt_ring  = '0;
        end else if (stop_p) begin
          nxt_ring  = '0;
`ifdef ALARM_SNOOZE_EN
          nxt_state = ST_SNOOZE;
          nxt_snz   = '0;
`else
          nxt_state = ST_ARMED;
`endif
        end else if (ring_cnt >= RING_END) begin
          nxt_state = ST_ARMED;
          nxt_ring  = '0;
        end else if (clk_1hz_tick) begin
          nxt_ring = ring_cnt + 1'b1;
        end
      end
`ifdef ALARM_SNOOZE_EN
      ST_SNOOZE: begin
        if (alm_on_p) begin
          nxt_state = ST_OFF;
          nxt_snz   = '0;
        end else if (stop_p) begin
          nxt_state = ST_ARMED;
          nxt_snz   = '0;
        end else if (snz_cnt >= SNZ_END) begin
          nxt_state = ST_RINGING;
          nxt_ring  = '0;
          nxt_snz   = '0;
        end else if (clk_1hz_tick) begin
          nxt_snz = snz_cnt + 1'b1;
        end
      end
`endif
      default: nxt_state = ST_OFF;
    endcase
  end

  // Status outputs are decoded from the next state so they change on the same edge as state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_OFF;
      alm_hh        <= 8'h00;
      alm_mm        <= 8'h00;
      saved_armed   <= 1'b0;
      ring_cnt      <= '0;
      match_q       <= 1'b0;
      alm_edit      <= 1'b0;
      alm_blink_sel <= 1'b0;
      armed         <= 1'b0;
      ringing       <= 1'b0;
    end else begin
      state         <= nxt_state;
      alm_hh        <= nxt_hh;
      alm_mm        <= nxt_mm;
      saved_armed   <= nxt_saved;
      ring_cnt      <= nxt_ring;
      match_q       <= match;
      alm_edit      <= (nxt_state == ST_EDIT_HH) || (nxt_state == ST_EDIT_MM);
      alm_blink_sel <= (nxt_state == ST_EDIT_MM);
      armed         <= (nxt_state == ST_ARMED) || (nxt_state == ST_RINGING) ||
                       (nxt_state == ST_SNOOZE);
      ringing       <= (nxt_state == ST_RINGING);
    end
  end

`ifdef ALARM_SNOOZE_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      snz_cnt  <= '0;
      snoozing <= 1'b0;
    end else begin
      snz_cnt  <= nxt_snz;
      snoozing <= (nxt_state == ST_SNOOZE);
    end
  end
`else
  assign snoozing = 1'b0;
`endif

  alarm_tone_gen #(
    .CLK_FREQ (CLK_FREQ),
    .TONE_HZ  (TONE_HZ)
  ) u_tone (
    .clk  (clk),
    .rst  (rst),
    .en   (ringing),
    .tone (tone)
  );

  // Carrier only during even ring seconds.
  assign buzzer = ringing & tone & ~ring_cnt[0];

endmodule

// File: tb/tb_alarm_controller.sv
// tb/tb_alarm_controller.sv - directed self-checking bench for alarm_controller
module tb_alarm_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clk_1hz_tick = 1'b0;
  logic [7:0] cur_hh = 8'h00, cur_mm = 8'h00, cur_ss = 8'h00;
  logic       set_en = 1'b0;
  logic       alm_set_p = 1'b0, alm_sel_p = 1'b0, alm_inc_p = 1'b0;
  logic       alm_on_p = 1'b0, stop_p = 1'b0;
  logic [7:0] alm_hh, alm_mm;
  logic       alm_edit, alm_blink_sel, armed, ringing, snoozing, buzzer;

  localparam logic [4:0] P_SET = 5'b00001, P_SEL = 5'b00010, P_INC = 5'b00100,
                         P_ON = 5'b01000, P_STOP = 5'b10000;

  int n_tests = 0;
  int n_fail  = 0;
  int ones;

  always #5 clk = ~clk;

  alarm_controller #(
    .CLK_FREQ   (1000),
    .TONE_HZ    (100),
    .RING_SECS  (5),
    .SNOOZE_MIN (1)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .clk_1hz_tick  (clk_1hz_tick),
    .cur_hh        (cur_hh),
    .cur_mm        (cur_mm),
    .cur_ss        (cur_ss),
    .set_en        (set_en),
    .alm_set_p     (alm_set_p),
    .alm_sel_p     (alm_sel_p),
    .alm_inc_p     (alm_inc_p),
    .alm_on_p      (alm_on_p),
    .stop_p        (stop_p),
    .alm_hh        (alm_hh),
    .alm_mm        (alm_mm),
    .alm_edit      (alm_edit),
    .alm_blink_sel (alm_blink_sel),
    .armed         (armed),
    .ringing       (ringing),
    .snoozing      (snoozing),
    .buzzer        (buzzer)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic press(input logic [4:0] m, input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      {stop_p, alm_on_p, alm_inc_p, alm_sel_p, alm_set_p} = m;
      @(negedge clk);
      {stop_p, alm_on_p, alm_inc_p, alm_sel_p, alm_set_p} = 5'b0;
    end
  endtask

  task automatic tick1(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      clk_1hz_tick = 1'b1;
      @(negedge clk);
      clk_1hz_tick = 1'b0;
    end
  endtask

  task automatic set_cur(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    cur_hh = h;
    cur_mm = m;
    cur_ss = s;
  endtask

  // Step time 07:29:59 -> 07:30:00; returns one negedge after the matching edge.
  task automatic ring_now();
    set_cur(8'h07, 8'h29, 8'h59);
    @(negedge clk);
    set_cur(8'h07, 8'h30, 8'h00);
    @(negedge clk);
  endtask

  task automatic count_ring(input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (ringing) cnt++;
    end
  endtask

  task automatic count_buzz(input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (buzzer) cnt++;
    end
  endtask

  initial begin
    // 1. reset state and basic edit
    repeat (3) @(negedge clk);
    check("rst_hh", alm_hh, 8'h00);
    check("rst_mm", alm_mm, 8'h00);
    check("rst_flags", {alm_edit, alm_blink_sel, armed, ringing, snoozing, buzzer}, 6'b0);
    rst = 1'b0;
    press(P_SET);
    check("edit_enter", {alm_edit, alm_blink_sel}, 2'b10);
    press(P_INC, 7);
    check("hh_07", alm_hh, 8'h07);
    press(P_SEL);
    check("sel_mm", alm_blink_sel, 1'b1);
    press(P_INC, 30);
    check("mm_30", alm_mm, 8'h30);
    press(P_SET);
    check("edit_exit", {alm_edit, armed}, 2'b00);
    check("hh_kept", alm_hh, 8'h07);

    // 2. BCD wrap boundaries and sel/inc collision
    press(P_SET);
    press(P_INC, 16);
    check("hh_23", alm_hh, 8'h23);
    press(P_INC);
    check("hh_wrap", alm_hh, 8'h00);
    press(P_INC, 7);
    press(P_SEL);
    press(P_INC, 29);
    check("mm_59", alm_mm, 8'h59);
    press(P_INC);
    check("mm_wrap", alm_mm, 8'h00);
    press(P_INC, 9);
    check("mm_09", alm_mm, 8'h09);
    press(P_INC);
    check("mm_carry", alm_mm, 8'h10);
    press(P_INC, 20);
    press(P_SEL | P_INC);
    check("selinc_field", alm_blink_sel, 1'b0);
    check("selinc_mm", alm_mm, 8'h30);
    check("selinc_hh", alm_hh, 8'h07);
    press(P_SET);
    check("back_off", {alm_edit, armed}, 2'b00);

    // 3. arm, trigger, buzzer gating, auto-silence
    set_cur(8'h07, 8'h29, 8'h59);
    press(P_ON);
    check("armed", armed, 1'b1);
    set_cur(8'h07, 8'h30, 8'h00);
    check("pre_ring", ringing, 1'b0);
    @(negedge clk);
    check("ring_latency", ringing, 1'b1);
    repeat (4) @(negedge clk);
    check("tone_low", buzzer, 1'b0);
    @(negedge clk);
    check("tone_high", buzzer, 1'b1);
    repeat (4) @(negedge clk);
    check("tone_high_end", buzzer, 1'b1);
    @(negedge clk);
    check("tone_low2", buzzer, 1'b0);
    tick1();
    count_buzz(12, ones);
    check("odd_sec_quiet", ones, 0);
    tick1();
    count_buzz(12, ones);
    check("even_sec_tone", ones > 0, 1'b1);
    tick1(2);
    check("ring_at4", ringing, 1'b1);
    tick1();
    @(negedge clk);
    check("auto_silence", {ringing, armed}, 2'b01);
    count_ring(10, ones);
    check("no_retrigger", ones, 0);

    // 4. stop while ringing
    ring_now();
    check("ring2", ringing, 1'b1);
`ifdef ALARM_SNOOZE_EN
    press(P_STOP);
    check("snooze", {snoozing, ringing, armed}, 3'b101);
    press(P_STOP);
    check("snooze_stop", {snoozing, ringing, armed}, 3'b001);
    ring_now();
    press(P_STOP);
    tick1(59);
    check("snooze_59", {snoozing, ringing}, 2'b10);
    tick1();
    @(negedge clk);
    check("snooze_ring", {snoozing, ringing}, 2'b01);
    press(P_STOP);
    press(P_STOP);
    check("snooze_armed", {snoozing, ringing, armed}, 3'b001);
`else
    press(P_STOP);
    check("stop", {snoozing, ringing, armed}, 3'b001);
    count_ring(10, ones);
    check("stop_no_retrig", ones, 0);
`endif

    // 5. disarm wins over stop; set_en and arm-while-matching suppress ring
    ring_now();
    press(P_ON | P_STOP);
    check("on_wins", {armed, ringing}, 2'b00);
    press(P_ON);
    count_ring(10, ones);
    check("arm_on_match", {armed, ones[7:0]}, {1'b1, 8'd0});
    set_en = 1'b1;
    ring_now();
    count_ring(4, ones);
    check("set_en_block", ones, 0);
    set_en = 1'b0;

    // 6. reset mid-ring
    ring_now();
    check("ring3", ringing, 1'b1);
    repeat (5) @(negedge clk);
    check("buzz_before_rst", buzzer, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    check("rst_ring", {ringing, buzzer, armed, snoozing}, 4'b0);
    check("rst_alarm", {alm_hh, alm_mm}, 16'h0000);
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
